// File: rtl/uart_rx_cfg_if.sv
// Receive-side stream interface of the configurable UART receiver:
// word, status flags and a valid/ready handshake towards the consumer.
interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] o_RxData;
    logic                 o_RxValid;
    logic                 i_RxReady;
    logic                 o_ParityErr;
    logic                 o_FrameErr;
    logic                 o_Overrun;
    logic                 o_Busy;

    modport master (
        output o_RxData, o_RxValid, o_ParityErr, o_FrameErr, o_Overrun, o_Busy,
        input  i_RxReady
    );

    modport slave (
        input  o_RxData, o_RxValid, o_ParityErr, o_FrameErr, o_Overrun, o_Busy,
        output i_RxReady
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, none/even/odd parity, 1 or 2 stop bits,
// start-glitch rejection, parity/framing/overrun reporting and a valid/ready output.
module uart_rx_cfg #(
    parameter int SYS_CLOCK     = 50000000,
    parameter int UART_BAUDRATE = 115200,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1
) (
    input  logic          i_SysClock,
    input  logic          i_ResetN,
    input  logic          i_RxSerial,
    uart_rx_cfg_if.master rx
);
    localparam int BIT_CYC  = int'((longint'(SYS_CLOCK) * 10 / UART_BAUDRATE + 5) / 10);
    localparam int HALF_CYC = (BIT_CYC + 1) / 2;
    localparam int CNT_W    = $clog2(BIT_CYC) + 1;
    localparam int IDX_W    = 4;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2);
    localparam logic             ODD_PAR   = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t               state_reg;
    logic                 sync1_reg;
    logic                 sync2_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic [IDX_W-1:0]     bit_idx_reg;
    logic                 stop_idx_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 perr_reg;
    logic                 ferr_reg;
    logic                 done_reg;
    logic [DATA_BITS-1:0] data_reg;
    logic                 valid_reg;
    logic                 perr_out_reg;
    logic                 ferr_out_reg;
    logic                 overrun_reg;
    logic                 busy_reg;
    logic                 line;

    assign line = sync2_reg;

    always_ff @(posedge i_SysClock or negedge i_ResetN) begin
        if (!i_ResetN) begin
            state_reg    <= S_IDLE;
            sync1_reg    <= 1'b1;
            sync2_reg    <= 1'b1;
            cnt_reg      <= '0;
            bit_idx_reg  <= '0;
            stop_idx_reg <= 1'b0;
            shift_reg    <= '0;
            perr_reg     <= 1'b0;
            ferr_reg     <= 1'b0;
            done_reg     <= 1'b0;
            data_reg     <= '0;
            valid_reg    <= 1'b0;
            perr_out_reg <= 1'b0;
            ferr_out_reg <= 1'b0;
            overrun_reg  <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            sync1_reg   <= i_RxSerial;
            sync2_reg   <= sync1_reg;
            done_reg    <= 1'b0;
            overrun_reg <= 1'b0;

            if (valid_reg && rx.i_RxReady)
                valid_reg <= 1'b0;

            // A finished frame loads only if the held word is gone or leaving this cycle.
            if (done_reg) begin
                if (!valid_reg || rx.i_RxReady) begin
                    data_reg     <= shift_reg;
                    perr_out_reg <= perr_reg;
                    ferr_out_reg <= ferr_reg;
                    valid_reg    <= 1'b1;
                end else begin
                    overrun_reg <= 1'b1;
                end
            end

            case (state_reg)
                S_IDLE: begin
                    if (!line) begin
                        state_reg <= S_START;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        perr_reg  <= 1'b0;
                        ferr_reg  <= 1'b0;
                    end
                end
                S_START: begin
                    if (cnt_reg == HALF_LAST) begin
                        cnt_reg <= '0;
                        if (line) begin
                            state_reg <= S_IDLE;
                            busy_reg  <= 1'b0;
                        end else begin
                            state_reg   <= S_DATA;
                            bit_idx_reg <= '0;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (cnt_reg == BIT_LAST) begin
                        cnt_reg   <= '0;
                        shift_reg <= {line, shift_reg[DATA_BITS-1:1]};
                        if (bit_idx_reg == IDX_LAST) begin
                            state_reg    <= (PARITY != 0) ? S_PAR : S_STOP;
                            stop_idx_reg <= 1'b0;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + IDX_W'(1);
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                S_PAR: begin
                    if (cnt_reg == BIT_LAST) begin
                        cnt_reg      <= '0;
                        perr_reg     <= ((^shift_reg) ^ line) != ODD_PAR;
                        state_reg    <= S_STOP;
                        stop_idx_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (cnt_reg == BIT_LAST) begin
                        cnt_reg  <= '0;
                        ferr_reg <= ferr_reg | ~line;
                        if (stop_idx_reg == STOP_LAST) begin
                            done_reg <= 1'b1;
                            // A bad stop bit may be a break; hold off until the line idles.
                            if (ferr_reg || !line) begin
                                state_reg <= S_WAIT_IDLE;
                            end else begin
                                state_reg <= S_IDLE;
                                busy_reg  <= 1'b0;
                            end
                        end else begin
                            stop_idx_reg <= 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                S_WAIT_IDLE: begin
                    if (line) begin
                        state_reg <= S_IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign rx.o_RxData    = data_reg;
    assign rx.o_RxValid   = valid_reg;
    assign rx.o_ParityErr = perr_out_reg;
    assign rx.o_FrameErr  = ferr_out_reg;
    assign rx.o_Overrun   = overrun_reg;
    assign rx.o_Busy      = busy_reg;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three receivers (8N1, 7E1, 8O2) at 10 clocks per bit.
module tb_uart_rx_cfg;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n [3];
    logic ser   [3];
    logic ready [3];

    uart_rx_cfg_if #(.DATA_BITS(8)) if0 ();
    uart_rx_cfg_if #(.DATA_BITS(7)) if1 ();
    uart_rx_cfg_if #(.DATA_BITS(8)) if2 ();

    assign if0.i_RxReady = ready[0];
    assign if1.i_RxReady = ready[1];
    assign if2.i_RxReady = ready[2];

    uart_rx_cfg #(.SYS_CLOCK(1000000), .UART_BAUDRATE(100000)) dut0 (
        .i_SysClock(clk), .i_ResetN(rst_n[0]), .i_RxSerial(ser[0]), .rx(if0));
    uart_rx_cfg #(.SYS_CLOCK(1000000), .UART_BAUDRATE(100000), .DATA_BITS(7), .PARITY(1)) dut1 (
        .i_SysClock(clk), .i_ResetN(rst_n[1]), .i_RxSerial(ser[1]), .rx(if1));
    uart_rx_cfg #(.SYS_CLOCK(1000000), .UART_BAUDRATE(100000), .PARITY(2), .STOP_BITS(2)) dut2 (
        .i_SysClock(clk), .i_ResetN(rst_n[2]), .i_RxSerial(ser[2]), .rx(if2));

    logic       v  [3];
    logic       ov [3];
    logic       bz [3];
    logic       pe [3];
    logic       fe [3];
    logic [8:0] dat[3];

    assign v[0] = if0.o_RxValid;   assign v[1] = if1.o_RxValid;   assign v[2] = if2.o_RxValid;
    assign ov[0] = if0.o_Overrun;  assign ov[1] = if1.o_Overrun;  assign ov[2] = if2.o_Overrun;
    assign bz[0] = if0.o_Busy;     assign bz[1] = if1.o_Busy;     assign bz[2] = if2.o_Busy;
    assign pe[0] = if0.o_ParityErr; assign pe[1] = if1.o_ParityErr; assign pe[2] = if2.o_ParityErr;
    assign fe[0] = if0.o_FrameErr; assign fe[1] = if1.o_FrameErr; assign fe[2] = if2.o_FrameErr;
    assign dat[0] = {1'b0, if0.o_RxData};
    assign dat[1] = {2'b0, if1.o_RxData};
    assign dat[2] = {1'b0, if2.o_RxData};

    // Word monitor: counts valid rising edges and overrun cycles, latches each new word.
    int         rise_cnt [3] = '{default: 0};
    int         ovr_cnt  [3] = '{default: 0};
    logic       prev_v   [3] = '{default: 1'b0};
    logic [8:0] cap_data [3] = '{default: '0};
    logic       cap_perr [3] = '{default: 1'b0};
    logic       cap_ferr [3] = '{default: 1'b0};

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (v[i] && !prev_v[i]) begin
                rise_cnt[i] = rise_cnt[i] + 1;
                cap_data[i] = dat[i];
                cap_perr[i] = pe[i];
                cap_ferr[i] = fe[i];
            end
            if (ov[i])
                ovr_cnt[i] = ovr_cnt[i] + 1;
            prev_v[i] = v[i];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Bit 0 of bits goes on the wire first; the line is left at the last bit.
    task automatic send(input int d, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ser[d] = bits[i];
            tick(10);
        end
    endtask

    task automatic wait_rise(input int d, input int prev, input string tag);
        int k = 0;
        while (rise_cnt[d] == prev && k < 300) begin
            tick(1);
            k++;
        end
        check(tag, 32'(rise_cnt[d] != prev), 32'd1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int o;
        int k;
        logic saw_busy;
        logic [15:0] fb;

        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0;
            ser[i]   = 1'b1;
            ready[i] = 1'b1;
        end
        tick(3);
        check("rst_valid", 32'(v[0]), 32'd0);
        check("rst_data",  32'(dat[0]), 32'd0);
        check("rst_busy",  32'(bz[0]), 32'd0);
        check("rst_flags", 32'({pe[0], fe[0], ov[0]}), 32'd0);
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
        tick(5);
        check("post_rst_idle", 32'({v[0], bz[0], v[1], bz[1], v[2], bz[2]}), 32'd0);

        // 8N1 word 0xA5 with the consumer always ready
        r = rise_cnt[0];
        send(0, 16'({1'b1, 8'hA5, 1'b0}), 10);
        wait_rise(0, r, "t1_valid_timeout");
        tick(5);
        check("t1_data",    32'(cap_data[0]), 32'hA5);
        check("t1_flags",   32'({cap_perr[0], cap_ferr[0]}), 32'd0);
        check("t1_once",    32'(rise_cnt[0]), 32'(r + 1));
        check("t1_dropped", 32'(v[0]), 32'd0);
        check("t1_overrun", 32'(ovr_cnt[0]), 32'd0);

        // 7E1: 0x35 has four ones, so the even parity bit is 0
        r = rise_cnt[1];
        send(1, 16'({1'b1, 1'b0, 7'h35, 1'b0}), 10);
        wait_rise(1, r, "t2a_valid_timeout");
        tick(3);
        check("t2a_data", 32'(cap_data[1]), 32'h35);
        check("t2a_perr", 32'(cap_perr[1]), 32'd0);
        check("t2a_ferr", 32'(cap_ferr[1]), 32'd0);
        r = rise_cnt[1];
        send(1, 16'({1'b1, 1'b1, 7'h35, 1'b0}), 10);
        wait_rise(1, r, "t2b_valid_timeout");
        tick(3);
        check("t2b_data", 32'(cap_data[1]), 32'h35);
        check("t2b_perr", 32'(cap_perr[1]), 32'd1);
        check("t2b_ferr", 32'(cap_ferr[1]), 32'd0);

        // 8O2: 0x00 with correct odd parity 1, second stop bit 0, line then held low
        r = rise_cnt[2];
        send(2, 16'({1'b0, 1'b1, 1'b1, 8'h00, 1'b0}), 12);
        wait_rise(2, r, "t3a_valid_timeout");
        tick(2);
        check("t3a_data", 32'(cap_data[2]), 32'h00);
        check("t3a_ferr", 32'(cap_ferr[2]), 32'd1);
        check("t3a_perr", 32'(cap_perr[2]), 32'd0);
        tick(30);
        check("t3_wait_busy", 32'(bz[2]), 32'd1);
        check("t3_one_word",  32'(rise_cnt[2]), 32'(r + 1));
        ser[2] = 1'b1;
        tick(5);
        check("t3_idle_again", 32'(bz[2]), 32'd0);
        r = rise_cnt[2];
        send(2, 16'({1'b1, 1'b1, 1'b1, 8'h3C, 1'b0}), 12);
        wait_rise(2, r, "t3b_valid_timeout");
        tick(2);
        check("t3b_data",  32'(cap_data[2]), 32'h3C);
        check("t3b_flags", 32'({cap_perr[2], cap_ferr[2]}), 32'd0);

        // Start glitch: 3 low cycles must be rejected
        r = rise_cnt[0];
        saw_busy = 1'b0;
        ser[0] = 1'b0;
        tick(3);
        ser[0] = 1'b1;
        k = 0;
        while (k < 8) begin
            tick(1);
            if (bz[0]) saw_busy = 1'b1;
            else if (saw_busy) break;
            k++;
        end
        check("t4_saw_busy", 32'(saw_busy), 32'd1);
        check("t4_busy_low", 32'(bz[0]), 32'd0);
        tick(20);
        check("t4_no_word",  32'(rise_cnt[0]), 32'(r));

        // Overrun: consumer stalled, second frame is discarded
        ready[0] = 1'b0;
        r = rise_cnt[0];
        send(0, 16'({1'b1, 8'h11, 1'b0}), 10);
        wait_rise(0, r, "t5_valid_timeout");
        tick(2);
        check("t5_first", 32'(cap_data[0]), 32'h11);
        o = ovr_cnt[0];
        send(0, 16'({1'b1, 8'h22, 1'b0}), 10);
        k = 0;
        while (ovr_cnt[0] == o && k < 100) begin
            tick(1);
            k++;
        end
        tick(3);
        check("t5_ovr_pulse", 32'(ovr_cnt[0]), 32'(o + 1));
        check("t5_held_data", 32'(dat[0]), 32'h11);
        check("t5_held_valid", 32'(v[0]), 32'd1);
        check("t5_no_new_word", 32'(rise_cnt[0]), 32'(r + 1));
        ready[0] = 1'b1;
        tick(1);
        check("t5_valid_drop", 32'(v[0]), 32'd0);

        // Reset during data bit 3 of a frame, with a word held
        ready[0] = 1'b0;
        r = rise_cnt[0];
        send(0, 16'({1'b1, 8'h77, 1'b0}), 10);
        wait_rise(0, r, "t6_hold_timeout");
        fb = 16'({1'b1, 8'h5A, 1'b0});
        send(0, fb, 4);
        ser[0] = fb[4];
        tick(5);
        check("t6_busy_before", 32'({bz[0], v[0]}), 32'b11);
        #2;
        rst_n[0] = 1'b0;
        #1;
        check("t6_async_clear", 32'({v[0], bz[0], pe[0], fe[0], ov[0]}), 32'd0);
        check("t6_async_data",  32'(dat[0]), 32'd0);
        ser[0] = 1'b1;
        tick(3);
        rst_n[0] = 1'b1;
        ready[0] = 1'b1;
        tick(20);
        r = rise_cnt[0];
        send(0, fb, 10);
        wait_rise(0, r, "t6_valid_timeout");
        tick(2);
        check("t6_data",  32'(cap_data[0]), 32'h5A);
        check("t6_flags", 32'({cap_perr[0], cap_ferr[0]}), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
